// File: rtl/pico_stream_master.sv
// pico_stream_master
//   Stream-fed requester for the PicoRV32 native memory bus. A header word and an
//   address word start a burst of sequential word reads or writes. Write data comes
//   in on din; read data goes out on dout.
//   Optional feature macro: MEM_TIMEOUT_EN. When defined, a request that waits TIMEOUT
//   cycles for mem_ready is abandoned, err is set and the command ends with done.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a header word
//   S_ADDR  | header taken, waiting for the start address word
//   S_WDATA | waiting for the next write data word
//   S_WBUS  | write request on the bus, waiting for mem_ready
//   S_RBUS  | read request on the bus, waiting for mem_ready
//   S_RPUSH | read word held on dout until the consumer takes it
module pico_stream_master #(
  parameter int LEN_BITS = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        val_in,
  output logic        ready_upward,
  output logic [31:0] dout,
  output logic        val_out,
  input  logic        ready_downward,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WBUS, S_RBUS, S_RPUSH
  } state_t;

  state_t              state;
  logic                is_write;
  logic [LEN_BITS-1:0] remain;
  logic                last_word;
  logic                wait_expired;

  assign last_word    = (remain == LEN_BITS'(1));
  assign ready_upward = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
  assign busy         = (state != S_IDLE);
  assign mem_instr    = 1'b0;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Down-counter reloads whenever no request is pending, so each new request starts a fresh budget.
  always_ff @(posedge clk) begin
    if (reset || !mem_valid) wait_cnt <= WAIT_W'(TIMEOUT - 1);
    else if (!mem_ready && wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
  end

  assign wait_expired = mem_valid && !mem_ready && (wait_cnt == '0);
`else
  assign wait_expired = 1'b0;
`endif

  // Command sequencing with all bus and stream outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      is_write  <= 1'b0;
      remain    <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'h0;
      val_out   <= 1'b0;
      dout      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (val_in) begin
            is_write <= din[31];
            remain   <= din[LEN_BITS-1:0];
            err      <= 1'b0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (val_in) begin
            mem_addr <= {din[31:2], 2'b00};
            if (remain == '0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (is_write) begin
              state <= S_WDATA;
            end else begin
              mem_valid <= 1'b1;
              mem_wstrb <= 4'h0;
              state     <= S_RBUS;
            end
          end
        end
        S_WDATA: begin
          if (val_in) begin
            mem_wdata <= din;
            mem_wstrb <= 4'hF;
            mem_valid <= 1'b1;
            state     <= S_WBUS;
          end
        end
        S_WBUS: begin
          if (wait_expired) begin
            mem_valid <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= S_IDLE;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= mem_addr + 32'd4;
            remain    <= remain - LEN_BITS'(1);
            if (last_word) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_WDATA;
            end
          end
        end
        S_RBUS: begin
          if (wait_expired) begin
            mem_valid <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= S_IDLE;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            dout      <= mem_rdata;
            val_out   <= 1'b1;
            state     <= S_RPUSH;
          end
        end
        S_RPUSH: begin
          if (ready_downward) begin
            val_out  <= 1'b0;
            mem_addr <= mem_addr + 32'd4;
            remain   <= remain - LEN_BITS'(1);
            if (last_word) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              mem_valid <= 1'b1;
              state     <= S_RBUS;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_stream_master.sv
// Testbench for pico_stream_master: responder and consumer models, expected traffic
// derived from the command words (addresses, data, read-back function).
module tb_pico_stream_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        val_in;
  logic        ready_upward;
  logic [31:0] dout;
  logic        val_out;
  logic        ready_downward;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy, done, err;

  int checks = 0;
  int passed = 0;

  // responder model
  bit          resp_en = 1'b1;
  int          resp_delay = 1;
  int          resp_wait = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] rq_addr[$];
  logic [31:0] rd_mem[logic [31:0]];

  // consumer model and monitor
  bit          cons_rand = 1'b1;
  logic        cons_manual = 1'b0;
  logic [31:0] pop_q[$];
  int          done_cnt = 0, mv_rises = 0, vo_cycles = 0, unstable = 0;
  logic        prev_mv = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [3:0]  prev_strb = '0;

  pico_stream_master #(.LEN_BITS(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .din(din), .val_in(val_in), .ready_upward(ready_upward),
    .dout(dout), .val_out(val_out), .ready_downward(ready_downward),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (rd_mem.exists(a)) return rd_mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // responder: acknowledges after resp_delay waiting cycles, logs each completed access
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) mem_ready = 1'b0;
      else if (!mem_valid || reset) resp_wait = 0;
      else if (resp_en) begin
        if (resp_wait >= resp_delay) begin
          mem_ready = 1'b1;
          resp_wait = 0;
          if (mem_wstrb != 4'h0) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_strb.push_back(mem_wstrb);
          end else begin
            rq_addr.push_back(mem_addr);
            mem_rdata = rd_word(mem_addr);
          end
        end else resp_wait++;
      end
    end
  end

  // consumer ready driver
  initial begin
    ready_downward = 1'b0;
    forever begin
      @(negedge clk);
      ready_downward = cons_rand ? 1'($urandom_range(0, 1)) : cons_manual;
    end
  end

  // monitor, sampled after the input drivers have settled
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (done) done_cnt++;
        if (val_out) vo_cycles++;
        if (val_out && ready_downward) pop_q.push_back(dout);
        if (mem_valid && !prev_mv) mv_rises++;
        if (mem_valid && prev_mv && (mem_addr !== prev_addr || mem_wdata !== prev_wdata ||
                                     mem_wstrb !== prev_strb)) unstable++;
      end
      prev_mv = mem_valid; prev_addr = mem_addr; prev_wdata = mem_wdata; prev_strb = mem_wstrb;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required all tests finished");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    din = w; val_in = 1'b1; n = 0;
    while (!ready_upward && n < 5000) begin @(negedge clk); n++; end
    if (!ready_upward) begin
      checks++;
      $display("FAIL send_word: ready_upward=0 after %0d cycles, required 1", n);
      val_in = 1'b0;
      return;
    end
    @(negedge clk);
    val_in = 1'b0;
    din = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b, required 0", busy);
    else passed++;
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); wq_strb.delete(); rq_addr.delete(); pop_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; val_in = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if ({mem_valid, val_out, done, err, busy} !== 5'b0)
      $display("FAIL reset_flags: mv,vo,done,err,busy=%b required 00000",
               {mem_valid, val_out, done, err, busy}); else passed++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: %h required 0", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: %h required 0", mem_wdata); else passed++;
    checks++; if (mem_wstrb !== 4'h0) $display("FAIL reset_wstrb: %h required 0", mem_wstrb); else passed++;
    checks++; if (dout !== 32'h0) $display("FAIL reset_dout: %h required 0", dout); else passed++;
    checks++; if (ready_upward !== 1'b1) $display("FAIL reset_ready: %b required 1", ready_upward); else passed++;
    checks++; if (mem_instr !== 1'b0) $display("FAIL mem_instr: %b required 0", mem_instr); else passed++;
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic test_write();
    logic [31:0] d[3];
    int d0;
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    resp_delay = 2; clear_logs(); d0 = done_cnt;
    send_word(32'h8000_0003);
    send_word(32'h0000_1000);
    send_word(d[0]);
    checks++; if (mem_valid !== 1'b1) $display("FAIL write_latency: mem_valid=%b required 1", mem_valid); else passed++;
    send_word(d[1]);
    send_word(d[2]);
    wait_idle();
    checks++; if (wq_addr.size() != 3) $display("FAIL write_count: %0d required 3", wq_addr.size()); else passed++;
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      checks++; if (wq_addr[i] !== 32'h1000 + 32'(4 * i))
        $display("FAIL write_addr[%0d]: %h required %h", i, wq_addr[i], 32'h1000 + 32'(4 * i)); else passed++;
      checks++; if (wq_data[i] !== d[i] || wq_strb[i] !== 4'hF)
        $display("FAIL write_data[%0d]: %h/%h required %h/F", i, wq_data[i], wq_strb[i], d[i]); else passed++;
    end
    checks++; if (done_cnt - d0 != 1) $display("FAIL write_done: %0d pulses required 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_read();
    int n, m0;
    rd_mem[32'h2000] = 32'h11; rd_mem[32'h2004] = 32'h22;
    resp_delay = 1; clear_logs(); cons_rand = 1'b0; cons_manual = 1'b0;
    @(negedge clk);
    #2;
    m0 = mv_rises;
    send_word(32'h0000_0002);
    send_word(32'h0000_2002);
    n = 0;
    while (!val_out && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (val_out !== 1'b1 || dout !== 32'h11 || mem_valid !== 1'b0)
        $display("FAIL read_hold[%0d]: vo=%b dout=%h mv=%b required 1/00000011/0",
                 i, val_out, dout, mem_valid); else passed++;
      @(negedge clk);
    end
    checks++; if (mv_rises - m0 != 1) $display("FAIL read_early_req: %0d requests required 1", mv_rises - m0); else passed++;
    #2 cons_manual = 1'b1;
    @(negedge clk);
    #2 cons_manual = 1'b0;
    @(negedge clk);
    n = 0;
    while (!val_out && n < 200) begin @(negedge clk); n++; end
    checks++; if (val_out !== 1'b1 || dout !== 32'h22)
      $display("FAIL read_second: vo=%b dout=%h required 1/00000022", val_out, dout); else passed++;
    #2 cons_manual = 1'b1;
    @(negedge clk);
    #2 cons_manual = 1'b0;
    cons_rand = 1'b1;
    wait_idle();
    checks++; if (pop_q.size() != 2 || pop_q[0] !== 32'h11 || pop_q[1] !== 32'h22)
      $display("FAIL read_data: %0d words required 11,22", pop_q.size()); else passed++;
    checks++; if (rq_addr.size() != 2 || rq_addr[0] !== 32'h2000 || rq_addr[1] !== 32'h2004)
      $display("FAIL read_addr: %0d requests required 2000,2004", rq_addr.size()); else passed++;
  endtask

  task automatic test_zero_len();
    int d0, m0;
    d0 = done_cnt; m0 = mv_rises;
    send_word(32'h7FFF_0000);
    send_word(32'h0000_1234);
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_done: done=%b busy=%b required 1/0", done, busy); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL zero_pulse: done=%b required 0", done); else passed++;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (mv_rises != m0 || done_cnt - d0 != 1)
      $display("FAIL zero_bus: requests=%0d done=%0d required 0/1", mv_rises - m0, done_cnt - d0); else passed++;
  endtask

  task automatic test_wrap();
    clear_logs(); resp_delay = 0;
    send_word(32'h8000_0002);
    send_word(32'hFFFF_FFFC);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    wait_idle();
    checks++; if (wq_addr.size() != 2 || wq_addr[0] !== 32'hFFFF_FFFC || wq_addr[1] !== 32'h0)
      $display("FAIL wrap_addr: %0d writes required FFFFFFFC,00000000", wq_addr.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int d0;
    resp_en = 1'b0; d0 = done_cnt;
    send_word(32'h8000_0003);
    send_word(32'h0000_5000);
    send_word(32'hDEAD_0001);
    checks++; if (mem_valid !== 1'b1) $display("FAIL midrst_pre: mem_valid=%b required 1", mem_valid); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || busy !== 1'b0 || val_out !== 1'b0)
      $display("FAIL midrst_state: mv=%b busy=%b vo=%b required 0/0/0", mem_valid, busy, val_out); else passed++;
    reset = 1'b0;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (done_cnt != d0) $display("FAIL midrst_done: %0d pulses required 0", done_cnt - d0); else passed++;
    clear_logs();
    send_word(32'h8000_0001);
    send_word(32'h0000_6000);
    send_word(32'h1234_5678);
    wait_idle();
    checks++; if (wq_addr.size() != 1 || wq_addr[0] !== 32'h6000 || wq_data[0] !== 32'h1234_5678)
      $display("FAIL midrst_next: %0d writes required 1 to 6000", wq_addr.size()); else passed++;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int d0, v0, hi;
    resp_en = 1'b0; d0 = done_cnt; v0 = vo_cycles;
    send_word(32'h0000_0002);
    send_word(32'h0000_3000);
    hi = 0;
    while (mem_valid && hi < 100) begin @(negedge clk); hi++; end
    checks++; if (hi != 8) $display("FAIL timeout_len: mem_valid %0d cycles required 8", hi); else passed++;
    checks++; if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_err: err=%b busy=%b required 1/0", err, busy); else passed++;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (done_cnt - d0 != 1 || vo_cycles != v0)
      $display("FAIL timeout_done: done=%0d vo=%0d required 1/0", done_cnt - d0, vo_cycles - v0); else passed++;
    resp_en = 1'b1;
    send_word(32'h0000_0000);
    checks++; if (err !== 1'b0) $display("FAIL timeout_clear: err=%b required 0", err); else passed++;
    send_word(32'h0000_0000);
    wait_idle();
  endtask
`else
  task automatic test_no_timeout();
    resp_en = 1'b0; clear_logs(); cons_rand = 1'b1;
    send_word(32'h0000_0001);
    send_word(32'h0000_4000);
    repeat (40) @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || err !== 1'b0 || busy !== 1'b1)
      $display("FAIL stall: mv=%b err=%b busy=%b required 1/0/1", mem_valid, err, busy); else passed++;
    resp_en = 1'b1;
    wait_idle();
    checks++; if (pop_q.size() != 1 || pop_q[0] !== rd_word(32'h4000))
      $display("FAIL stall_data: %0d words required 1", pop_q.size()); else passed++;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 20; c++) begin
      bit          wr;
      int          n, d0, m0;
      logic [31:0] a, base, w;
      logic [31:0] exp_d[$];
      wr = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 6);
      a = $urandom;
      base = {a[31:2], 2'b00};
      resp_delay = $urandom_range(0, 4);
      cons_rand = 1'b1;
      clear_logs(); exp_d.delete();
      d0 = done_cnt; m0 = mv_rises;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word({wr, 15'($urandom), 16'(n)});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(a);
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          w = $urandom;
          exp_d.push_back(w);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send_word(w);
        end
      end
      wait_idle();
      checks++; if (done_cnt - d0 != 1 || mv_rises - m0 != n)
        $display("FAIL rand%0d_count: done=%0d req=%0d required 1/%0d", c, done_cnt - d0, mv_rises - m0, n);
      else passed++;
      if (wr) begin
        checks++; if (wq_addr.size() != n) $display("FAIL rand%0d_writes: %0d required %0d", c, wq_addr.size(), n); else passed++;
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
          checks++; if (wq_addr[i] !== base + 32'(4 * i) || wq_data[i] !== exp_d[i] || wq_strb[i] !== 4'hF)
            $display("FAIL rand%0d_w%0d: %h=%h required %h=%h", c, i, wq_addr[i], wq_data[i],
                     base + 32'(4 * i), exp_d[i]); else passed++;
        end
      end else begin
        checks++; if (pop_q.size() != n) $display("FAIL rand%0d_reads: %0d required %0d", c, pop_q.size(), n); else passed++;
        for (int i = 0; i < n && i < pop_q.size() && i < rq_addr.size(); i++) begin
          checks++; if (rq_addr[i] !== base + 32'(4 * i) || pop_q[i] !== rd_word(base + 32'(4 * i)))
            $display("FAIL rand%0d_r%0d: %h->%h required %h->%h", c, i, rq_addr[i], pop_q[i],
                     base + 32'(4 * i), rd_word(base + 32'(4 * i))); else passed++;
        end
      end
    end
    checks++; if (unstable != 0) $display("FAIL bus_stable: %0d changes while mem_valid, required 0", unstable); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_zero_len();
    test_wrap();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
